wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 64, meaning write-back data width.
REQ-002 The block SHALL have parameter AW, default 5, meaning register address width (2^AW registers).
REQ-003 The block SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req0_valid  input  1  ALU write-back request.
REQ-006 The block SHALL have port req0_addr  input  AW  ALU destination register.
REQ-007 The block SHALL have port req0_data  input  DW  ALU result.
REQ-008 The block SHALL have port req0_ready  output  1  ALU request accepted this cycle.
REQ-009 The block SHALL have ports req1_valid, req1_addr, req1_data and req1_ready with the same widths, serving the load unit.
REQ-010 The block SHALL have port iss_valid  input  1  instruction issued with a destination register.
REQ-011 The block SHALL have port iss_addr  input  AW  destination register being reserved.
REQ-012 The block SHALL have port Ad_c  output  AW  register bank write address.
REQ-013 The block SHALL have port data_wr  output  DW  register bank write data.
REQ-014 The block SHALL have port wr_acc  output  1  register bank write enable.
REQ-015 The block SHALL have port busy  output  2^AW  scoreboard, bit n set while register n has a pending write.
REQ-016 The block SHALL have port err  output  1  sticky flag, set on a write-back to a register that is not busy.

Function
REQ-017 Accept SHALL be reqN_valid and reqN_ready in the same cycle; a requester holds valid, addr and data stable until accepted.
REQ-018 At most one of req0_ready and req1_ready SHALL be high per cycle; readyN is combinational from the valids and the priority pointer.
REQ-019 With a single valid requester, that requester SHALL be granted in the same cycle.
REQ-020 With both valid, round-robin SHALL apply: grant goes to the requester not granted last; the pointer updates only on a grant.
REQ-021 An accepted request SHALL drive Ad_c and data_wr, with wr_acc=1, from the next rising edge for exactly one cycle (latency 1).
REQ-022 A cycle with no accept SHALL leave wr_acc=0 next cycle; Ad_c and data_wr SHALL hold their previous values.
REQ-023 An accepted write to address 0 SHALL be consumed with wr_acc held 0; register 0 is never written.
REQ-024 An issue with iss_valid=1 SHALL set busy[iss_addr] at the next edge; an issue to address 0 SHALL be ignored.
REQ-025 An accept SHALL clear busy[addr] at the next edge.
REQ-026 A set and a clear of the same bit in the same cycle SHALL leave the bit set, because the new reservation wins.
REQ-027 An accept to a nonzero address whose busy bit is 0 SHALL set err, and the write SHALL still be performed.
REQ-028 err SHALL remain set until reset.

Reset
REQ-029 When rst=1 at a rising edge: wr_acc=0, Ad_c=0, data_wr=0, busy=0, err=0, and the pointer favours req0.
REQ-030 During rst=1, both readys SHALL be 0; any request in flight is dropped and must be re-presented.
REQ-031 Reset SHALL take priority over any simultaneous issue or accept.

Configuration
REQ-032 With WBARB_FIXED_PRIO_EN defined, req1 (load) SHALL always win when both requesters are valid, and no pointer state SHALL be implemented.
REQ-033 Without WBARB_FIXED_PRIO_EN, the round-robin of REQ-020 SHALL apply.

Verification
REQ-034 Reset, issue r5, then req0 writes r5=0x1234 -> next cycle wr_acc=1, Ad_c=5, data_wr=0x1234; busy[5] goes 1 then 0; err=0.
REQ-035 Both valid for 4 cycles with distinct targets, default build -> grants alternate 0,1,0,1; with WBARB_FIXED_PRIO_EN -> req1 granted until it drops valid.
REQ-036 Accepted req1 write to r0 -> wr_acc stays 0, busy unchanged, err=0.
REQ-037 Issue r7 in the same cycle as an accept of r7 -> busy[7]=1 afterwards and the write is performed.
REQ-038 Write r9 while busy[9]=0 -> err=1, which persists; rst pulse -> err=0, busy=0.
REQ-039 rst asserted while req0_valid is held -> req0_ready=0 and wr_acc=0 throughout reset; accepted on the first cycle after reset.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: write-back requests, issue reservations and register-bank write port of wb_arbiter
interface wb_arbiter_if #(
   parameter int DW = 64,
   parameter int AW = 5
);
   logic                 req0_valid;
   logic [AW-1:0]        req0_addr;
   logic [DW-1:0]        req0_data;
   logic                 req0_ready;
   logic                 req1_valid;
   logic [AW-1:0]        req1_addr;
   logic [DW-1:0]        req1_data;
   logic                 req1_ready;
   logic                 iss_valid;
   logic [AW-1:0]        iss_addr;
   logic [AW-1:0]        Ad_c;
   logic [DW-1:0]        data_wr;
   logic                 wr_acc;
   logic [(1<<AW)-1:0]   busy;
   logic                 err;
   modport slave (
      input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, iss_valid, iss_addr,
      output req0_ready, req1_ready, Ad_c, data_wr, wr_acc, busy, err
   );
   modport master (
      output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, iss_valid, iss_addr,
      input  req0_ready, req1_ready, Ad_c, data_wr, wr_acc, busy, err
   );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: ALU/load write-back arbiter with busy scoreboard; define WBARB_FIXED_PRIO_EN to give the load unit fixed priority
module wb_arbiter #(
   parameter int DW = 64,
   parameter int AW = 5
) (
   input  logic        clk,
   input  logic        rst,
   wb_arbiter_if.slave bus
);
   localparam int NR = 1 << AW;
   logic          gnt0, gnt1, acc, wr_d, wr_q, err_d, err_q;
   logic [AW-1:0] sel_addr, ad_d, ad_q;
   logic [DW-1:0] sel_data, dat_d, dat_q;
   logic [NR-1:0] set_m, clr_m, busy_d, busy_q;
`ifdef WBARB_FIXED_PRIO_EN
   // Load unit wins every tie; nothing is granted while in reset
   always_comb begin
      gnt1 = !rst && bus.req1_valid;
      gnt0 = !rst && bus.req0_valid && !bus.req1_valid;
   end
`else
   logic prio_d, prio_q;
   // Round-robin: prio_q names the tie winner and flips to the other side after each grant
   always_comb begin
      gnt0   = !rst && bus.req0_valid && (!bus.req1_valid || !prio_q);
      gnt1   = !rst && bus.req1_valid && (!bus.req0_valid || prio_q);
      prio_d = gnt0 ? 1'b1 : gnt1 ? 1'b0 : prio_q;
   end
   // Pointer register, favouring req0 out of reset
   always_ff @(posedge clk) prio_q <= rst ? 1'b0 : prio_d;
`endif
   // Select the winner, drop r0 writes, and update scoreboard with new reservations overriding clears
   always_comb begin
      acc      = gnt0 || gnt1;
      sel_addr = gnt1 ? bus.req1_addr : bus.req0_addr;
      sel_data = gnt1 ? bus.req1_data : bus.req0_data;
      wr_d     = acc && (sel_addr != '0);
      ad_d     = wr_d ? sel_addr : ad_q;
      dat_d    = wr_d ? sel_data : dat_q;
      set_m    = (bus.iss_valid && bus.iss_addr != '0) ? (NR'(1) << bus.iss_addr) : '0;
      clr_m    = wr_d ? (NR'(1) << sel_addr) : '0;
      busy_d   = (busy_q & ~clr_m) | set_m;
      err_d    = err_q || (wr_d && !busy_q[sel_addr]);
   end
   // Write port, scoreboard and sticky error state
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= 1'b0;
         ad_q   <= '0;
         dat_q  <= '0;
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wr_q   <= wr_d;
         ad_q   <= ad_d;
         dat_q  <= dat_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end
   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.wr_acc     = wr_q;
   assign bus.Ad_c       = ad_q;
   assign bus.data_wr    = dat_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a scoreboard-level reference model
module tb_wb_arbiter;
   localparam int DW = 64, AW = 5, NR = 1 << AW;
   logic clk = 0;
   logic rst = 1;
   always #5 clk = ~clk;
   wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();
   wb_arbiter #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
   int n = 0, nf = 0;
   bit            busy_m [NR];
   bit            err_m, exp_wr, ad_known;
   logic [AW-1:0] exp_ad;
   logic [DW-1:0] exp_dat;
   int            last_g = 1;

   function automatic int model_grant();
      if (rst) return -1;
      if (bus.req0_valid && bus.req1_valid)
`ifdef WBARB_FIXED_PRIO_EN
         return 1;
`else
         return (last_g == 0) ? 1 : 0;
`endif
      if (bus.req0_valid) return 0;
      if (bus.req1_valid) return 1;
      return -1;
   endfunction

   task automatic idle();
      bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
      bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
      bus.iss_valid = 0; bus.iss_addr = '0;
   endtask

   task automatic step(input logic iv, input logic [AW-1:0] ia, output int g, output int obs);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [NR-1:0] bv;
      logic [1:0]    er;
      bus.iss_valid = iv;
      bus.iss_addr  = ia;
      g  = model_grant();
      er = (g == 1) ? 2'b10 : (g == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
      obs = bus.req1_ready ? 1 : bus.req0_ready ? 0 : -1;
      n++;
      if ({bus.req1_ready, bus.req0_ready} !== er) begin
         nf++;
         $display("FAIL ready t=%0t got %b expected %b", $time, {bus.req1_ready, bus.req0_ready}, er);
      end
      @(posedge clk);
      if (rst) begin
         foreach (busy_m[i]) busy_m[i] = 0;
         err_m = 0; last_g = 1; exp_wr = 0; exp_ad = '0; exp_dat = '0; ad_known = 1;
      end else begin
         exp_wr = 0;
         if (g >= 0) begin
            a = (g == 1) ? bus.req1_addr : bus.req0_addr;
            d = (g == 1) ? bus.req1_data : bus.req0_data;
            last_g = g;
            if (a != 0) begin
               exp_wr = 1; exp_ad = a; exp_dat = d; ad_known = 1;
               if (!busy_m[a]) err_m = 1;
               busy_m[a] = 0;
            end else ad_known = 0;
         end
         if (iv && ia != 0) busy_m[ia] = 1;
      end
      #1;
      for (int i = 0; i < NR; i++) bv[i] = busy_m[i];
      n++;
      if (bus.wr_acc !== exp_wr) begin
         nf++; $display("FAIL wr_acc t=%0t got %b expected %b", $time, bus.wr_acc, exp_wr);
      end
      if (ad_known) begin
         n++;
         if (bus.Ad_c !== exp_ad || bus.data_wr !== exp_dat) begin
            nf++; $display("FAIL write_port t=%0t got %0d/%h expected %0d/%h", $time, bus.Ad_c, bus.data_wr, exp_ad, exp_dat);
         end
      end
      n++;
      if (bus.busy !== bv) begin
         nf++; $display("FAIL busy t=%0t got %h expected %h", $time, bus.busy, bv);
      end
      n++;
      if (bus.err !== err_m) begin
         nf++; $display("FAIL err t=%0t got %b expected %b", $time, bus.err, err_m);
      end
   endtask

   task automatic do_reset();
      int g, o;
      idle();
      rst = 1;
      step(0, '0, g, o);
      step(0, '0, g, o);
      rst = 0;
   endtask

   task automatic test_reset();
      int g, o;
      idle();
      rst = 1;
      bus.req0_valid = 1; bus.req0_addr = 5'd3; bus.req0_data = 64'hCAFE;
      for (int i = 0; i < 3; i++) begin
         step(1, 5'd6, g, o);
         n++;
         if (o != -1) begin nf++; $display("FAIL reset_grant got %0d expected -1", o); end
      end
      n++;
      if (bus.busy !== '0 || bus.err !== 1'b0 || bus.Ad_c !== '0 || bus.data_wr !== '0) begin
         nf++; $display("FAIL reset_state busy=%h err=%b Ad_c=%0d data=%h expected all 0", bus.busy, bus.err, bus.Ad_c, bus.data_wr);
      end
      rst = 0;
      step(0, '0, g, o);
      n++;
      if (o != 0 || bus.wr_acc !== 1'b1 || bus.Ad_c !== 5'd3) begin
         nf++; $display("FAIL post_reset_accept grant=%0d wr_acc=%b Ad_c=%0d expected 0/1/3", o, bus.wr_acc, bus.Ad_c);
      end
      idle();
   endtask

   task automatic test_basic();
      int g, o;
      do_reset();
      step(1, 5'd5, g, o);
      n++;
      if (bus.busy[5] !== 1'b1) begin nf++; $display("FAIL basic_busy_set got %b expected 1", bus.busy[5]); end
      bus.req0_valid = 1; bus.req0_addr = 5'd5; bus.req0_data = 64'h1234;
      step(0, '0, g, o);
      n++;
      if (bus.wr_acc !== 1'b1 || bus.Ad_c !== 5'd5 || bus.data_wr !== 64'h1234 || bus.busy[5] !== 1'b0 || bus.err !== 1'b0) begin
         nf++; $display("FAIL basic_write wr_acc=%b Ad_c=%0d data=%h busy5=%b err=%b expected 1/5/1234/0/0", bus.wr_acc, bus.Ad_c, bus.data_wr, bus.busy[5], bus.err);
      end
      idle();
      step(0, '0, g, o);
      n++;
      if (bus.wr_acc !== 1'b0 || bus.Ad_c !== 5'd5 || bus.data_wr !== 64'h1234) begin
         nf++; $display("FAIL basic_hold wr_acc=%b Ad_c=%0d data=%h expected 0/5/1234", bus.wr_acc, bus.Ad_c, bus.data_wr);
      end
   endtask

   task automatic test_round_robin();
      int g, o;
`ifdef WBARB_FIXED_PRIO_EN
      int exp_seq[4] = '{1, 1, 1, 1};
`else
      int exp_seq[4] = '{0, 1, 0, 1};
`endif
      do_reset();
      bus.req0_valid = 1; bus.req0_addr = 5'd1; bus.req0_data = 64'hA0;
      bus.req1_valid = 1; bus.req1_addr = 5'd2; bus.req1_data = 64'hB0;
      for (int i = 0; i < 4; i++) begin
         step(0, '0, g, o);
         n++;
         if (o != exp_seq[i]) begin nf++; $display("FAIL rr_grant[%0d] got %0d expected %0d", i, o, exp_seq[i]); end
         if (o == 0) begin bus.req0_addr = bus.req0_addr + 5'd2; bus.req0_data = bus.req0_data + 1; end
         if (o == 1) begin bus.req1_addr = bus.req1_addr + 5'd2; bus.req1_data = bus.req1_data + 1; end
      end
      bus.req1_valid = 0;
      step(0, '0, g, o);
      n++;
      if (o != 0) begin nf++; $display("FAIL rr_single got %0d expected 0", o); end
      idle();
   endtask

   task automatic test_r0();
      int g, o;
      do_reset();
      step(1, 5'd4, g, o);
      bus.req1_valid = 1; bus.req1_addr = '0; bus.req1_data = 64'hDEAD;
      step(0, '0, g, o);
      n++;
      if (o != 1 || bus.wr_acc !== 1'b0 || bus.busy !== (NR'(1) << 4) || bus.err !== 1'b0) begin
         nf++; $display("FAIL r0_write grant=%0d wr_acc=%b busy=%h err=%b expected 1/0/10/0", o, bus.wr_acc, bus.busy, bus.err);
      end
      idle();
   endtask

   task automatic test_collision();
      int g, o;
      do_reset();
      step(1, 5'd7, g, o);
      bus.req0_valid = 1; bus.req0_addr = 5'd7; bus.req0_data = 64'h77;
      step(1, 5'd7, g, o);
      n++;
      if (bus.busy[7] !== 1'b1 || bus.wr_acc !== 1'b1 || bus.Ad_c !== 5'd7 || bus.data_wr !== 64'h77 || bus.err !== 1'b0) begin
         nf++; $display("FAIL collision busy7=%b wr_acc=%b Ad_c=%0d data=%h err=%b expected 1/1/7/77/0", bus.busy[7], bus.wr_acc, bus.Ad_c, bus.data_wr, bus.err);
      end
      idle();
   endtask

   task automatic test_err();
      int g, o;
      do_reset();
      bus.req1_valid = 1; bus.req1_addr = 5'd9; bus.req1_data = 64'h99;
      step(0, '0, g, o);
      n++;
      if (bus.err !== 1'b1 || bus.wr_acc !== 1'b1 || bus.Ad_c !== 5'd9) begin
         nf++; $display("FAIL err_set err=%b wr_acc=%b Ad_c=%0d expected 1/1/9", bus.err, bus.wr_acc, bus.Ad_c);
      end
      idle();
      for (int i = 0; i < 3; i++) step(1, 5'd12, g, o);
      n++;
      if (bus.err !== 1'b1) begin nf++; $display("FAIL err_sticky got %b expected 1", bus.err); end
      do_reset();
      n++;
      if (bus.err !== 1'b0 || bus.busy !== '0) begin
         nf++; $display("FAIL err_clear err=%b busy=%h expected 0/0", bus.err, bus.busy);
      end
   endtask

   task automatic test_random();
      int g, o;
      do_reset();
      for (int c = 0; c < 500; c++) begin
         if (!bus.req0_valid && $urandom_range(0, 2) != 0) begin
            bus.req0_valid = 1; bus.req0_addr = AW'($urandom); bus.req0_data = {$urandom, $urandom};
         end
         if (!bus.req1_valid && $urandom_range(0, 2) != 0) begin
            bus.req1_valid = 1; bus.req1_addr = AW'($urandom); bus.req1_data = {$urandom, $urandom};
         end
         rst = ($urandom_range(0, 59) == 0);
         step(1'($urandom_range(0, 1)), AW'($urandom), g, o);
         if (g == 0) bus.req0_valid = 0;
         if (g == 1) bus.req1_valid = 0;
      end
      rst = 0;
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_basic();
      test_round_robin();
      test_r0();
      test_collision();
      test_err();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n, nf);
      $finish;
   end
endmodule
